// File: rtl/fda_capture_pkg.sv
// Capture sequencer shared definitions: FSM state encodings,
// trigger-source mode codes, the DRAIN guard length and a small width helper.
package fda_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_RECORD    = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_HOLDOFF   = 3'd5
    } state_t;

    localparam logic [1:0] MODE_IMM  = 2'b00;
    localparam logic [1:0] MODE_EXT  = 2'b01;
    localparam logic [1:0] MODE_SELF = 2'b10;

    localparam int DRAIN_GUARD = 4;

    function automatic int max3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/capture_sequencer.sv
// Capture sequencer: arms a trigger, records rec_len+1 samples, drains the
// FIFO and optionally re-arms after a holdoff. One shared down-counter times
// every phase. All outputs are registered.
// Ports:
//   clk, reset_n            clock, async active-low reset (sync release inside)
//   start, abort            one-cycle requests (abort wins)
//   mode, auto_rearm        trigger source, re-arm after completion
//   rec_len, tmo_len        capture length-1, trigger timeout (0 = none)
//   ext_trig, self_trig     trigger levels
//   clk_ok, fifo_empty      ADC clock lock, capture FIFO empty
//   record, trig_arm,       FIFO write enable, comparator arm,
//   trig_reset              comparator reset pulse
//   busy, done, err, state  status outputs
module capture_sequencer
    import fda_capture_pkg::*;
#(
    parameter int LEN_W       = 12,
    parameter int TMO_W       = 16,
    parameter int HOLDOFF_CYC = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic             auto_rearm,
    input  logic [LEN_W-1:0] rec_len,
    input  logic [TMO_W-1:0] tmo_len,
    input  logic             ext_trig,
    input  logic             self_trig,
    input  logic             clk_ok,
    input  logic             fifo_empty,
    output logic             record,
    output logic             trig_arm,
    output logic             trig_reset,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       state
);

    localparam int CNT_W =
        max3(LEN_W, TMO_W, $clog2(HOLDOFF_CYC + DRAIN_GUARD) + 1);

    // Reset asserts asynchronously, releases two clk edges later.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_mode;
    logic [LEN_W-1:0]   r_len;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_record;
    logic               r_trig_arm;
    logic               r_trig_reset;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    state_t             w_next;
    logic [CNT_W-1:0]   w_cnt_dec;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_err_nxt;
    logic               w_done_nxt;
    logic               w_latch;
    logic               w_trig;
    logic               w_imm;
    logic               w_tmo_hit;
    logic               w_cnt_zero;

    assign w_trig = ((r_mode == MODE_EXT) && ext_trig) ||
                    ((r_mode == MODE_SELF) && self_trig);
    // Mode 11 behaves like immediate.
    assign w_imm      = !((r_mode == MODE_EXT) || (r_mode == MODE_SELF));
    assign w_cnt_zero = (r_cnt == '0);
    assign w_tmo_hit  = (r_tmo != '0) && w_cnt_zero;
    // Counter saturates at zero so long phases simply wait there.
    assign w_cnt_dec  = w_cnt_zero ? r_cnt : r_cnt - CNT_W'(1);

    always_comb begin
        w_next     = r_state;
        w_err_nxt  = r_err;
        w_done_nxt = 1'b0;
        w_latch    = 1'b0;
        if (abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (clk_ok) begin
                            w_next    = ST_ARM;
                            w_latch   = 1'b1;
                            w_err_nxt = 1'b0;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
                ST_ARM: begin
                    w_next = w_imm ? ST_RECORD : ST_WAIT_TRIG;
                end
                ST_WAIT_TRIG: begin
                    if (!clk_ok) begin
                        w_next    = ST_IDLE;
                        w_err_nxt = 1'b1;
                    end else if (w_trig || w_tmo_hit) begin
                        w_next = ST_RECORD;
                    end
                end
                ST_RECORD: begin
                    if (!clk_ok) begin
                        w_next    = ST_IDLE;
                        w_err_nxt = 1'b1;
                    end else if (w_cnt_zero) begin
                        w_next = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_cnt_zero && fifo_empty) begin
                        w_done_nxt = 1'b1;
                        w_next     = auto_rearm ? ST_HOLDOFF : ST_IDLE;
                    end
                end
                ST_HOLDOFF: begin
                    if (w_cnt_zero) begin
                        w_next = ST_ARM;
                    end
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end
    end

    // Reload the shared counter with the length of the phase being entered.
    always_comb begin
        w_cnt_nxt = w_cnt_dec;
        if (w_next != r_state) begin
            case (w_next)
                ST_WAIT_TRIG: w_cnt_nxt = CNT_W'(r_tmo) - CNT_W'(1);
                ST_RECORD:    w_cnt_nxt = CNT_W'(r_len);
                ST_DRAIN:     w_cnt_nxt = CNT_W'(DRAIN_GUARD - 1);
                ST_HOLDOFF:   w_cnt_nxt = CNT_W'(HOLDOFF_CYC - 1);
                default:      w_cnt_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_mode       <= MODE_IMM;
            r_len        <= '0;
            r_tmo        <= '0;
            r_record     <= 1'b0;
            r_trig_arm   <= 1'b0;
            r_trig_reset <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_cnt        <= w_cnt_nxt;
            r_record     <= (w_next == ST_RECORD);
            r_trig_arm   <= (w_next == ST_WAIT_TRIG);
            r_trig_reset <= (w_next == ST_ARM);
            r_busy       <= (w_next != ST_IDLE);
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
            if (w_latch) begin
                r_mode <= mode;
                r_len  <= rec_len;
                r_tmo  <= tmo_len;
            end
        end
    end

    assign record     = r_record;
    assign trig_arm   = r_trig_arm;
    assign trig_reset = r_trig_reset;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign state      = r_state;

endmodule

// File: tb/tb_capture_sequencer.sv
// Self-checking bench for capture_sequencer: table vectors for IDLE
// decisions, directed multi-cycle sequences and randomized captures.
module tb_capture_sequencer;

    localparam int LEN_W = 12;
    localparam int TMO_W = 16;
    localparam int HOLD  = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic             abort;
    logic [1:0]       mode;
    logic             auto_rearm;
    logic [LEN_W-1:0] rec_len;
    logic [TMO_W-1:0] tmo_len;
    logic             ext_trig;
    logic             self_trig;
    logic             clk_ok;
    logic             fifo_empty;
    logic             record;
    logic             trig_arm;
    logic             trig_reset;
    logic             busy;
    logic             done;
    logic             err;
    logic [2:0]       state;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    capture_sequencer #(
        .LEN_W(LEN_W),
        .TMO_W(TMO_W),
        .HOLDOFF_CYC(HOLD)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .abort(abort),
        .mode(mode),
        .auto_rearm(auto_rearm),
        .rec_len(rec_len),
        .tmo_len(tmo_len),
        .ext_trig(ext_trig),
        .self_trig(self_trig),
        .clk_ok(clk_ok),
        .fifo_empty(fifo_empty),
        .record(record),
        .trig_arm(trig_arm),
        .trig_reset(trig_reset),
        .busy(busy),
        .done(done),
        .err(err),
        .state(state)
    );

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int all_out();
        return int'({record, trig_arm, trig_reset, busy, done, err, state});
    endfunction

    // Timeline model: edge numbers counted from the edge that samples start.
    task automatic run_capture(input string tag, input logic [1:0] md,
                               input int rl, input int tmo, input int d,
                               input int e, input logic rearm);
        int  wt;
        int  rise;
        int  fall;
        int  dn;
        int  ts2;
        int  o_rise  = -1;
        int  o_cnt   = 0;
        int  o_arm   = 0;
        int  o_trst  = 0;
        int  o_ts2   = -1;
        int  o_done  = -1;
        int  o_state = -1;
        int  o_err   = -1;
        bit  s_ext;
        bit  s_self;
        s_ext  = (md == 2'b01);
        s_self = (md == 2'b10);
        if (s_ext || s_self) begin
            wt = (tmo != 0 && tmo < d + 1) ? tmo : d + 1;
        end else begin
            wt = 0;
        end
        rise = 2 + wt;
        fall = rise + rl + 1;
        dn   = fall + ((e + 1 > 4) ? e + 1 : 4);
        ts2  = rearm ? dn + HOLD : -1;
        mode       = md;
        rec_len    = LEN_W'(rl);
        tmo_len    = TMO_W'(tmo);
        auto_rearm = rearm;
        fifo_empty = 1'b0;
        ext_trig   = 1'b0;
        self_trig  = 1'b0;
        clk_ok     = 1'b1;
        start      = 1'b1;
        for (int n = 1; n <= dn + HOLD + 1; n++) begin
            tick();
            start   = 1'b0;
            mode    = 2'($urandom);
            rec_len = LEN_W'($urandom);
            tmo_len = TMO_W'($urandom);
            if (record && n < dn) begin
                if (o_rise < 0) o_rise = n;
                o_cnt++;
            end
            if (trig_arm && n < dn) o_arm++;
            if (trig_reset) begin
                if (n < dn) o_trst++;
                else if (o_ts2 < 0) o_ts2 = n;
            end
            if (done && o_done < 0) o_done = n;
            if (n == dn) begin
                o_state = int'(state);
                o_err   = int'(err);
            end
            ext_trig   = s_ext ? (n >= 2 + d) : 1'($urandom_range(0, 1));
            self_trig  = s_self ? (n >= 2 + d) : 1'($urandom_range(0, 1));
            fifo_empty = (n >= fall + e);
        end
        abort = 1'b1;
        tick();
        abort      = 1'b0;
        auto_rearm = 1'b0;
        ext_trig   = 1'b0;
        self_trig  = 1'b0;
        check({tag, " rec_rise"}, o_rise, rise);
        check({tag, " rec_len"}, o_cnt, rl + 1);
        check({tag, " arm_cyc"}, o_arm, wt);
        check({tag, " trst_cnt"}, o_trst, 1);
        check({tag, " done_edge"}, o_done, dn);
        check({tag, " state_done"}, o_state, rearm ? 5 : 0);
        check({tag, " err_done"}, o_err, 0);
        check({tag, " rearm_edge"}, o_ts2, ts2);
    endtask

    typedef struct {
        logic       st;
        logic       ab;
        logic       ok;
        logic [1:0] md;
        logic [5:0] exp;
    } vec_t;

    vec_t vt[6];

    initial begin
        int dones;
        reset_n    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        mode       = 2'b00;
        auto_rearm = 1'b0;
        rec_len    = '0;
        tmo_len    = '0;
        ext_trig   = 1'b0;
        self_trig  = 1'b0;
        clk_ok     = 1'b1;
        fifo_empty = 1'b0;
        #3;
        check("reset_outputs", all_out(), 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        tick();

        // exp = {state, err, busy, trig_reset}
        vt[0] = '{1'b1, 1'b0, 1'b1, 2'b00, {3'd1, 1'b0, 1'b1, 1'b1}};
        vt[1] = '{1'b1, 1'b0, 1'b0, 2'b00, {3'd0, 1'b1, 1'b0, 1'b0}};
        vt[2] = '{1'b1, 1'b1, 1'b1, 2'b00, {3'd0, 1'b1, 1'b0, 1'b0}};
        vt[3] = '{1'b0, 1'b0, 1'b0, 2'b00, {3'd0, 1'b1, 1'b0, 1'b0}};
        vt[4] = '{1'b1, 1'b0, 1'b1, 2'b10, {3'd1, 1'b0, 1'b1, 1'b1}};
        vt[5] = '{1'b1, 1'b1, 1'b0, 2'b01, {3'd0, 1'b0, 1'b0, 1'b0}};
        for (int i = 0; i < 6; i++) begin
            start  = vt[i].st;
            abort  = vt[i].ab;
            clk_ok = vt[i].ok;
            mode   = vt[i].md;
            tick();
            start  = 1'b0;
            abort  = 1'b0;
            clk_ok = 1'b1;
            check($sformatf("vec%0d", i),
                  int'({state, err, busy, trig_reset}), int'(vt[i].exp));
            abort = 1'b1;
            tick();
            abort = 1'b0;
        end

        run_capture("imm_len9", 2'b00, 9, 0, 0, 0, 1'b0);
        run_capture("ext_d50", 2'b01, 5, 0, 50, 2, 1'b0);
        run_capture("self_tmo100", 2'b10, 3, 100, 300, 0, 1'b0);
        run_capture("mode3_max", 2'b11, 4095, 0, 0, 1, 1'b0);
        run_capture("rearm", 2'b00, 6, 0, 0, 20, 1'b1);
        run_capture("tmo1", 2'b01, 0, 1, 10, 3, 1'b0);

        // clk_ok lost at RECORD cycle 3
        mode    = 2'b00;
        rec_len = LEN_W'(9);
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 2; k <= 5; k++) tick();
        clk_ok = 1'b0;
        tick();
        clk_ok = 1'b1;
        check("clkok_drop", int'({state, err, record}), int'({3'd0, 1'b1, 1'b0}));
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done) dones++;
        end
        check("clkok_nodone", dones, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("clkok_errclr", int'({state, err}), int'({3'd1, 1'b0}));
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // abort while waiting for a trigger
        mode    = 2'b01;
        tmo_len = '0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("wait_arm", int'({state, trig_arm}), int'({3'd2, 1'b1}));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_wait", int'({state, trig_arm, busy, err}), 0);
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            ext_trig = 1'b1;
            tick();
            if (done || busy) dones++;
        end
        ext_trig = 1'b0;
        check("abort_quiet", dones, 0);

        // reset clears a sticky error
        clk_ok = 1'b0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        clk_ok = 1'b1;
        check("err_set", int'(err), 1);
        #2 reset_n = 1'b0;
        #1 check("reset_err", all_out(), 0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        tick();

        // reset in the middle of RECORD
        mode    = 2'b00;
        rec_len = LEN_W'(20);
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 2; k <= 4; k++) tick();
        check("mid_record", int'({state, record}), int'({3'd3, 1'b1}));
        #2 reset_n = 1'b0;
        #1 check("reset_midrec", all_out(), 0);
        dones = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done || record) dones++;
        end
        reset_n = 1'b1;
        tick();
        tick();
        tick();
        check("reset_hold", dones + all_out(), 0);

        for (int it = 0; it < 25; it++) begin
            int md;
            int rl;
            int tmo;
            int d;
            int e;
            md  = $urandom_range(0, 3);
            rl  = $urandom_range(0, 20);
            tmo = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 30);
            d   = $urandom_range(0, 40);
            e   = $urandom_range(0, 8);
            run_capture($sformatf("rnd%0d", it), 2'(md), rl, tmo, d, e,
                        1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
